cam_pixel_capture: RTL and testbench

- Parametrised camera capture front-end on the sensor PIXCLK domain, sitting between the DVP pins (VSYNC/HREF/PIXDATA) and the frame buffer write port.
- Packs 1- or 2-byte-per-pixel streams (Y8 / RGB565 / YUV) and applies a crop window and frame decimation.
- Emits frame-buffer-ready vs_n/de/data plus start-of-frame, end-of-line and line-error status.
- Replaces the hard-wired register-and-zero-extend Y8 path.

---
 rtl/cam_capture_pkg.sv | 20 ++
 rtl/cam_pixel_capture_if.sv | 17 +
 rtl/cam_byte_packer.sv | 46 ++++
 rtl/cam_pixel_capture.sv | 152 +++++++++++++++
 tb/tb_cam_pixel_capture.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the DVP pixel capture front-end.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    StSync,
    StVblank,
    StFrame
  } cap_state_e;

  localparam int unsigned BPP_Y8 = 1;
  localparam int unsigned BPP_16 = 2;

  function automatic bit params_legal(input int unsigned data_w, input int unsigned out_w,
                                      input int unsigned bpp, input int unsigned frame_div,
                                      input int unsigned cnt_w);
    return (bpp == BPP_Y8 || bpp == BPP_16) && (out_w >= data_w * bpp) &&
           (frame_div >= 1) && (cnt_w >= 1) && (data_w >= 1);
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Frame-buffer side of the capture block: sync, pixel strobe/data and status.
interface cam_pixel_capture_if #(
  parameter int unsigned OUT_W = 16
) ();

  logic             vs_n;
  logic             de;
  logic [OUT_W-1:0] data;
  logic             sof;
  logic             eol;
  logic             line_err;
  logic [7:0]       frame_cnt;

  modport master (output vs_n, de, data, sof, eol, line_err, frame_cnt);
  modport slave  (input  vs_n, de, data, sof, eol, line_err, frame_cnt);

endinterface

// File: rtl/cam_byte_packer.sv
// Assembles sensor bytes into pixels; flags a line that ends on a half pixel.
module cam_byte_packer
  import cam_capture_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned BYTES_PER_PIX = 1
) (
  input  logic              PIXCLK,
  input  logic              irst_n,
  input  logic              href,
  input  logic [DATA_W-1:0] data,
  output logic              pix_valid,
  output logic [OUT_W-1:0]  pix_data,
  output logic              odd_end
);

  logic              phase_q;
  logic [DATA_W-1:0] byte0_q;

  always_ff @(posedge PIXCLK or negedge irst_n) begin
    if (!irst_n) begin
      phase_q <= 1'b0;
      byte0_q <= '0;
    end else begin
      phase_q <= href ? ~phase_q : 1'b0;
      if (href && !phase_q) byte0_q <= data;
    end
  end

  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    odd_end   = 1'b0;
    if (BYTES_PER_PIX == BPP_16) begin
      pix_valid = href & phase_q;
      pix_data  = OUT_W'({byte0_q, data});
      // phase still set in the first idle cycle means the line stopped mid-pixel
      odd_end   = ~href & phase_q;
    end else begin
      pix_valid = href;
      pix_data  = OUT_W'(data);
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// DVP capture: frame sync FSM, crop window, frame decimation and output register.
module cam_pixel_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OUT_W          = 16,
  parameter int unsigned BYTES_PER_PIX  = 1,
  parameter bit          VS_ACTIVE_HIGH = 1'b1,
  parameter int unsigned CROP_X0        = 0,
  parameter int unsigned CROP_Y0        = 0,
  parameter int unsigned CROP_W         = 640,
  parameter int unsigned CROP_H         = 480,
  parameter int unsigned FRAME_DIV      = 1,
  parameter int unsigned CNT_W          = 12
) (
  input  logic                PIXCLK,
  input  logic                irst_n,
  input  logic                VSYNC,
  input  logic                HREF,
  input  logic [DATA_W-1:0]   PIXDATA,
  input  logic                i_enable,
  cam_pixel_capture_if.master fb
);

  if (!params_legal(DATA_W, OUT_W, BYTES_PER_PIX, FRAME_DIV, CNT_W)) begin : g_param_check
    $error("cam_pixel_capture: illegal parameter combination");
  end

  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   X_LO     = (CNT_W + 1)'(CROP_X0);
  localparam logic [CNT_W:0]   X_HI     = (CNT_W + 1)'(CROP_X0 + CROP_W);
  localparam logic [CNT_W:0]   X_LAST   = (CNT_W + 1)'(CROP_X0 + CROP_W - 1);
  localparam logic [CNT_W:0]   Y_LO     = (CNT_W + 1)'(CROP_Y0);
  localparam logic [CNT_W:0]   Y_HI     = (CNT_W + 1)'(CROP_Y0 + CROP_H);

  logic              s1_vs_q, s1_href_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              vs_prev_q, href_prev_q;
  cap_state_e        state_q;
  logic              keep_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  x_q, y_q;
  logic              line_err_q, vs_n_q, de_q, sof_q, eol_q;
  logic [OUT_W-1:0]  data_q;
  logic [7:0]        frame_cnt_q;

  logic             pix_valid, odd_end;
  logic [OUT_W-1:0] pix_data;

  cam_byte_packer #(
    .DATA_W       (DATA_W),
    .OUT_W        (OUT_W),
    .BYTES_PER_PIX(BYTES_PER_PIX)
  ) u_packer (
    .PIXCLK   (PIXCLK),
    .irst_n   (irst_n),
    .href     (s1_href_q),
    .data     (s1_data_q),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .odd_end  (odd_end)
  );

  logic           vs_act, vs_rise, vs_fall, href_fall, keep_new, in_frame;
  logic           x_in, y_in, emit, line_bad, abort;
  logic [CNT_W:0] x_ext, y_ext;

  always_comb begin
    vs_act    = VS_ACTIVE_HIGH ? s1_vs_q : ~s1_vs_q;
    vs_rise   = vs_act & ~vs_prev_q;
    vs_fall   = ~vs_act & vs_prev_q;
    href_fall = ~s1_href_q & href_prev_q;
    keep_new  = i_enable & (div_q == '0);
    in_frame  = (state_q == StFrame);
    x_ext     = {1'b0, x_q};
    y_ext     = {1'b0, y_q};
    x_in      = (x_ext >= X_LO) && (x_ext < X_HI);
    y_in      = (y_ext >= Y_LO) && (y_ext < Y_HI);
    // A byte arriving together with the vsync edge belongs to an aborted line.
    emit      = in_frame & keep_q & ~vs_rise & pix_valid & x_in & y_in;
    line_bad  = in_frame & keep_q & href_fall & (odd_end | (y_in & (x_ext < X_HI)));
    abort     = in_frame & keep_q & vs_rise & s1_href_q;
  end

  always_ff @(posedge PIXCLK or negedge irst_n) begin
    if (!irst_n) begin
      s1_vs_q     <= ~VS_ACTIVE_HIGH;
      s1_href_q   <= 1'b0;
      s1_data_q   <= '0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      state_q     <= StSync;
      keep_q      <= 1'b0;
      div_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_err_q  <= 1'b0;
      vs_n_q      <= 1'b1;
      de_q        <= 1'b0;
      data_q      <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      s1_vs_q     <= VSYNC;
      s1_href_q   <= HREF;
      s1_data_q   <= PIXDATA;
      vs_prev_q   <= vs_act;
      href_prev_q <= s1_href_q;

      case (state_q)
        StSync:   if (vs_rise) state_q <= StVblank;
        StVblank: if (vs_fall) state_q <= StFrame;
        StFrame:  if (vs_rise) state_q <= StVblank;
        default:  state_q <= StSync;
      endcase

      if (vs_rise) begin
        keep_q <= keep_new;
        div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end

      if (href_fall) x_q <= '0;
      else if (pix_valid && x_q != CNT_MAX) x_q <= x_q + 1'b1;

      if (vs_fall) y_q <= '0;
      else if (href_fall && y_q != CNT_MAX) y_q <= y_q + 1'b1;

      // An abort is reported against the frame that starts at the same edge.
      if (vs_rise) line_err_q <= abort;
      else if (line_bad) line_err_q <= 1'b1;

      vs_n_q <= ~(vs_act & (vs_rise ? keep_new : keep_q));
      de_q   <= emit;
      if (emit) data_q <= pix_data;
      sof_q  <= emit & (x_ext == X_LO) & (y_ext == Y_LO);
      eol_q  <= emit & (x_ext == X_LAST);
      frame_cnt_q <= frame_cnt_q + {7'd0, sof_q};
    end
  end

  assign fb.vs_n      = vs_n_q;
  assign fb.de        = de_q;
  assign fb.data      = data_q;
  assign fb.sof       = sof_q;
  assign fb.eol       = eol_q;
  assign fb.line_err  = line_err_q;
  assign fb.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Two capture instances (Y8 / 16-bit with decimation) on one sensor stream, scoreboard checked.
module tb_cam_pixel_capture;

  localparam int X0 = 1;
  localparam int Y0 = 1;
  localparam int W  = 4;
  localparam int H  = 2;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    time         due;
  } exp_t;

  logic       PIXCLK = 1'b0;
  logic       irst_n = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HREF = 1'b0;
  logic [7:0] PIXDATA = 8'h00;
  logic       i_enable = 1'b0;
  logic       vsync_n;

  always #5 PIXCLK = ~PIXCLK;
  assign vsync_n = ~VSYNC;

  cam_pixel_capture_if #(.OUT_W(16)) fb_a ();
  cam_pixel_capture_if #(.OUT_W(16)) fb_b ();

  cam_pixel_capture #(
    .DATA_W(8), .OUT_W(16), .BYTES_PER_PIX(1), .VS_ACTIVE_HIGH(1'b1), .CROP_X0(X0),
    .CROP_Y0(Y0), .CROP_W(W), .CROP_H(H), .FRAME_DIV(1), .CNT_W(12)
  ) dut_a (
    .PIXCLK(PIXCLK), .irst_n(irst_n), .VSYNC(VSYNC), .HREF(HREF), .PIXDATA(PIXDATA),
    .i_enable(i_enable), .fb(fb_a)
  );

  cam_pixel_capture #(
    .DATA_W(8), .OUT_W(16), .BYTES_PER_PIX(2), .VS_ACTIVE_HIGH(1'b0), .CROP_X0(X0),
    .CROP_Y0(Y0), .CROP_W(W), .CROP_H(H), .FRAME_DIV(3), .CNT_W(12)
  ) dut_b (
    .PIXCLK(PIXCLK), .irst_n(irst_n), .VSYNC(vsync_n), .HREF(HREF), .PIXDATA(PIXDATA),
    .i_enable(i_enable), .fb(fb_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = Y8 instance, 1 = 16-bit instance.
  int   bpp[2]  = '{1, 2};
  int   fdiv[2] = '{1, 3};
  int   div_m[2], fcnt_m[2], pulses_m[2], pulses_seen[2], de_seen[2];
  bit   keep_m[2], err_m[2];
  bit   in_frame = 1'b0;
  int   y_m = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] lbuf[$];
  logic vs_prev_a = 1'b1;
  logic vs_prev_b = 1'b1;

  function automatic bit in_win(input int x, input int y);
    return x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] data, input bit sof, input bit eol);
    exp_t e;
    e.data = data;
    e.sof  = sof;
    e.eol  = eol;
    e.due  = $time + 20;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    if (sof) fcnt_m[d] = (fcnt_m[d] + 1) % 256;
  endtask

  task automatic mon_check(input int d, input logic [15:0] data, input logic sof,
                           input logic eol);
    exp_t e;
    de_seen[d]++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_de dut%0d: got pixel %h, expected no pixel", d, data);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("data dut%0d", d), data, e.data);
    check($sformatf("sof dut%0d", d), sof, e.sof);
    check($sformatf("eol dut%0d", d), eol, e.eol);
    check($sformatf("latency dut%0d", d), $time, e.due);
  endtask

  always @(negedge PIXCLK) begin
    if (fb_a.de === 1'b1) mon_check(0, fb_a.data, fb_a.sof, fb_a.eol);
    if (fb_b.de === 1'b1) mon_check(1, fb_b.data, fb_b.sof, fb_b.eol);
    if (vs_prev_a && !fb_a.vs_n) pulses_seen[0]++;
    if (vs_prev_b && !fb_b.vs_n) pulses_seen[1]++;
    vs_prev_a = fb_a.vs_n;
    vs_prev_b = fb_b.vs_n;
  end

  task automatic drive(input bit vs, input bit href, input logic [7:0] d);
    @(negedge PIXCLK);
    VSYNC   = vs;
    HREF    = href;
    PIXDATA = d;
  endtask

  task automatic drive_byte(input int b);
    int x;
    logic [15:0] px;
    drive(1'b0, 1'b1, lbuf[b]);
    if (in_frame) begin
      for (int d = 0; d < 2; d++) begin
        if (keep_m[d] && (b % bpp[d] == bpp[d] - 1)) begin
          x  = b / bpp[d];
          px = (bpp[d] == 2) ? {lbuf[b-1], lbuf[b]} : {8'h00, lbuf[b]};
          if (in_win(x, y_m)) push(d, px, x == X0 && y_m == Y0, x == X0 + W - 1);
        end
      end
    end
  endtask

  task automatic send_line(input bit abort_next);
    for (int b = 0; b < lbuf.size(); b++) drive_byte(b);
    if (!abort_next) begin
      drive(1'b0, 1'b0, 8'h00);
      if (in_frame) begin
        for (int d = 0; d < 2; d++) begin
          if (keep_m[d] && ((lbuf.size() % bpp[d] != 0) ||
              (y_m >= Y0 && y_m < Y0 + H && lbuf.size() / bpp[d] < X0 + W)))
            err_m[d] = 1'b1;
        end
        y_m++;
      end
      repeat (2) drive(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic rand_line(input int n);
    lbuf.delete();
    for (int i = 0; i < n; i++) lbuf.push_back(8'($urandom));
  endtask

  task automatic frame_lines(input int nlines, input int nbytes);
    for (int l = 0; l < nlines; l++) begin
      rand_line(nbytes);
      send_line(1'b0);
    end
  endtask

  // Vertical sync: keep decision, error clear, then blanking into the next frame.
  task automatic vsync_pulse(input bit en, input bit abort);
    i_enable = en;
    for (int d = 0; d < 2; d++) begin
      err_m[d]  = abort && in_frame && keep_m[d];
      keep_m[d] = en && div_m[d] == 0;
      div_m[d]  = (div_m[d] + 1) % fdiv[d];
      if (keep_m[d]) pulses_m[d]++;
    end
    in_frame = 1'b0;
    drive(1'b1, abort, 8'($urandom));
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    check("vs_n dut0", fb_a.vs_n, !keep_m[0]);
    check("vs_n dut1", fb_b.vs_n, !keep_m[1]);
    check("line_err at vsync dut0", fb_a.line_err, err_m[0]);
    check("line_err at vsync dut1", fb_b.line_err, err_m[1]);
    drive(1'b0, 1'b0, 8'h00);
    in_frame = 1'b1;
    y_m = 0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_status();
    drive(1'b0, 1'b0, 8'h00);
    check("line_err dut0", fb_a.line_err, err_m[0]);
    check("line_err dut1", fb_b.line_err, err_m[1]);
    check("frame_cnt dut0", fb_a.frame_cnt, fcnt_m[0]);
    check("frame_cnt dut1", fb_b.frame_cnt, fcnt_m[1]);
    check("vs_n in frame dut0", fb_a.vs_n, 1);
    check("vs_n in frame dut1", fb_b.vs_n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      div_m[d] = 0; fcnt_m[d] = 0; pulses_m[d] = 0; pulses_seen[d] = 0; de_seen[d] = 0;
      keep_m[d] = 1'b0; err_m[d] = 1'b0;
    end
    repeat (3) @(negedge PIXCLK);
    check("reset vs_n dut0", fb_a.vs_n, 1);
    check("reset de dut1", fb_b.de, 0);
    irst_n = 1'b1;

    // Line data with no vsync seen since reset must not appear.
    frame_lines(2, 8);
    check("no de before vsync dut0", de_seen[0], 0);
    check("no de before vsync dut1", de_seen[1], 0);

    // Frame 0: 4 lines of 0x10+n.
    vsync_pulse(1'b1, 1'b0);
    for (int l = 0; l < 4; l++) begin
      lbuf.delete();
      for (int n = 0; n < 6; n++) lbuf.push_back(8'(8'h10 + n));
      send_line(1'b0);
    end
    check_status();

    vsync_pulse(1'b1, 1'b0);
    frame_lines(3, 10);
    check_status();

    vsync_pulse(1'b1, 1'b0);
    frame_lines(4, 10);
    check_status();

    // Frame 3: RGB565 pattern on line 1, odd-length line 2.
    vsync_pulse(1'b1, 1'b0);
    frame_lines(1, 10);
    rand_line(10);
    lbuf[0] = 8'h00; lbuf[1] = 8'h00; lbuf[2] = 8'hF8;
    lbuf[3] = 8'h1F; lbuf[4] = 8'h07; lbuf[5] = 8'hE0;
    send_line(1'b0);
    frame_lines(1, 7);
    check_status();

    // Frame 4: short line inside the window.
    vsync_pulse(1'b1, 1'b0);
    frame_lines(1, 10);
    frame_lines(1, 3);
    frame_lines(1, 10);
    check_status();

    // Frame 5: disabled at vsync, enabled mid-frame.
    vsync_pulse(1'b0, 1'b0);
    frame_lines(1, 10);
    i_enable = 1'b1;
    frame_lines(2, 10);
    check_status();
    check("frame_cnt after 6 frames dut1", fb_b.frame_cnt, 2);

    // Frame 6 ends with vsync arriving while HREF is high.
    vsync_pulse(1'b1, 1'b0);
    frame_lines(1, 10);
    rand_line(3);
    send_line(1'b1);
    vsync_pulse(1'b1, 1'b1);
    frame_lines(2, 10);

    // Reset in the middle of a line.
    rand_line(10);
    for (int b = 0; b < 4; b++) drive_byte(b);
    #3 irst_n = 1'b0;
    #1;
    check("midreset vs_n dut0", fb_a.vs_n, 1);
    check("midreset de dut0", fb_a.de, 0);
    check("midreset data dut0", fb_a.data, 0);
    check("midreset sof dut0", fb_a.sof, 0);
    check("midreset eol dut0", fb_a.eol, 0);
    check("midreset line_err dut0", fb_a.line_err, 0);
    check("midreset frame_cnt dut0", fb_a.frame_cnt, 0);
    check("midreset vs_n dut1", fb_b.vs_n, 1);
    check("midreset de dut1", fb_b.de, 0);
    check("midreset line_err dut1", fb_b.line_err, 0);
    check("midreset frame_cnt dut1", fb_b.frame_cnt, 0);
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      div_m[d] = 0; fcnt_m[d] = 0; keep_m[d] = 1'b0; err_m[d] = 1'b0;
    end
    in_frame = 1'b0;
    y_m = 0;
    @(negedge PIXCLK);
    irst_n = 1'b1;
    for (int b = 4; b < 10; b++) drive_byte(b);
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    vsync_pulse(1'b1, 1'b0);
    frame_lines(3, 10);
    check_status();

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    check("pending pixels dut0", q0.size(), 0);
    check("pending pixels dut1", q1.size(), 0);
    check("vs_n pulses dut0", pulses_seen[0], pulses_m[0]);
    check("vs_n pulses dut1", pulses_seen[1], pulses_m[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
